// File: rtl/or_unit_arbiter.sv
// or_unit_arbiter: round-robin arbiter that shares one WIDTH-bit OR datapath
// among NREQ requesters. One request is granted per cycle. Its a|b result and
// requester index go into a single-entry result register, which is drained
// through a valid/ready response channel. A drain and a new accept may happen
// in the same cycle, so the block sustains one result per cycle.
module or_unit_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDTH-1:0]      resp_data,
    output logic [IDW-1:0]        resp_id,
    output logic [15:0]           txn_count,
    output logic                  busy
);

    localparam logic [IDW:0]   NreqExt = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LastIdx = IDW'(NREQ - 1);

    // Architectural state
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_data_q,  resp_data_d;
    logic [IDW-1:0]   resp_id_q,    resp_id_d;
    logic [IDW-1:0]   ptr_q,        ptr_d;
    logic [15:0]      txn_count_q,  txn_count_d;

    // Arbitration signals
    logic             accept_ok;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [NREQ-1:0]  grant_vec;
    logic             accept;
    logic [WIDTH-1:0] or_result;
    logic [IDW-1:0]   ptr_inc;

    // The result slot can take a new entry when empty or being drained now
    assign accept_ok = ~resp_valid_q | resp_ready;

    // Round-robin search: first valid requester at ptr, ptr+1, ... mod NREQ
    always_comb begin
        logic [IDW:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= NreqExt) begin
                cand = cand - NreqExt;
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    // One-hot grant; suppressed while in reset or while the slot is blocked
    always_comb begin
        grant_vec = '0;
        if (!rst && accept_ok && grant_found) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    // A grant is only ever issued to a valid requester, so any grant is a transfer
    assign accept    = |grant_vec;
    assign req_ready = grant_vec;

    // Shared OR datapath fed by an AND-OR operand mux on the one-hot grant
    always_comb begin
        or_result = '0;
        for (int i = 0; i < NREQ; i++) begin
            or_result = or_result |
                ({WIDTH{grant_vec[i]}} & (req_a[i*WIDTH +: WIDTH] | req_b[i*WIDTH +: WIDTH]));
        end
    end

    // Pointer advances to the requester after the winner, wrapping at NREQ-1
    assign ptr_inc = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;

    // Next-state logic for the result register, pointer and counter
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        ptr_d        = ptr_q;
        txn_count_d  = txn_count_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_data_d  = or_result;
            resp_id_d    = grant_idx;
            ptr_d        = ptr_inc;
            if (txn_count_q != 16'hFFFF) begin
                txn_count_d = txn_count_q + 16'd1;
            end
        end else if (resp_valid_q && resp_ready) begin
            // Drained with nothing new: data and id keep their last values
            resp_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous reset; a pending result is discarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            ptr_q        <= '0;
            txn_count_q  <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            ptr_q        <= ptr_d;
            txn_count_q  <= txn_count_d;
        end
    end

    // All response outputs come straight from registers
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign txn_count  = txn_count_q;
    assign busy       = resp_valid_q;

endmodule

// File: doc/or_unit_arbiter.md
# or_unit_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit OR datapath (out = a | b) among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, computes the bitwise OR, and registers the result with the requester ID. It then returns the result on a single valid/ready response channel. It sits between the requester ports and the downstream consumer of gate results.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- NREQ, 4, number of requesters (2..16)
- IDW, $clog2(NREQ), derived localparam; width of resp_id
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  NREQ  bit i: requester i has an operand pair pending
- req_a  input  NREQ*WIDTH  operand A of requester i at bits [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand B of requester i, same packing
- req_ready  output  NREQ  one-hot-or-zero grant; transfer i occurs when req_valid[i] & req_ready[i] at clk edge
- resp_valid  output  1  result register holds an undelivered result
- resp_ready  input  1  consumer accepts the result this cycle
- resp_data  output  WIDTH  registered a | b of the granted request
- resp_id  output  IDW  index of the requester that produced resp_data
- txn_count  output  16  saturating count of accepted requests
- busy  output  1  equals resp_valid

## Operation
- State: result register (resp_valid, resp_data, resp_id), round-robin pointer ptr (IDW bits), txn_count.
- accept_ok = ~resp_valid | resp_ready (the result slot is empty or being drained this cycle).
- Grant: when accept_ok, grant the first i with req_valid[i], searching ptr, ptr+1, … wrapping mod NREQ. req_ready has exactly that bit set; otherwise req_ready = 0.
- req_ready is combinational from req_valid, ptr, resp_valid and resp_ready. req_ready[i] is never asserted without req_valid[i].
- On accept of requester g:
  - resp_data ← req_a[g] | req_b[g]
  - resp_id ← g
  - resp_valid ← 1
  - ptr ← (g+1) mod NREQ
  - txn_count ← txn_count+1, saturating at 0xFFFF
- resp_valid & resp_ready with no new accept: resp_valid ← 0. resp_data and resp_id hold their last values.
- Simultaneous drain and accept: the new result replaces the old one and resp_valid stays 1. Throughput is one result per cycle.
- resp_valid & ~resp_ready: all req_ready = 0, and resp_data, resp_id and ptr are held stable.
- ptr changes only on accept. Requests that are never granted leave ptr unchanged.
- NREQ not a power of two: ptr wraps from NREQ-1 to 0. It never takes an out-of-range value.

## Timing
- Reset values (applied asynchronously on rst=1, held while asserted):
  - resp_valid = 0, resp_data = 0, resp_id = 0, ptr = 0, txn_count = 0, busy = 0
  - req_ready = 0 while rst = 1
- Latency: request accepted at edge N gives resp_valid = 1 with the result from just after edge N, one cycle of latency.
- Reset asserted mid-transfer: a pending result is discarded with no response, and no grant is issued until after rst deasserts.
- First grant after reset is permitted at the first rising edge at which rst = 0.
- No combinational path from req_a/req_b to any output.

## Test plan
- Single request: req_valid = 0001, req_a[0] = 0x0F, req_b[0] = 0xF0, resp_ready = 1 → req_ready = 0001; next cycle resp_valid = 1, resp_data = 0xFF, resp_id = 0, txn_count = 1.
- Fairness: req_valid = 1111 held, resp_ready = 1, operands a_i = i, b_i = 0x10 → grants 0, 1, 2, 3, 0 on consecutive cycles; resp_data = 0x10, 0x11, 0x12, 0x13, 0x10.
- Backpressure: a result is pending, resp_ready = 0 for 3 cycles, req_valid = 1111 → req_ready = 0000 for all 3 cycles, resp_data/resp_id unchanged. On the cycle resp_ready = 1, the next grant issues and resp_valid stays 1.
- Pointer wrap: grant requester 2 (ptr becomes 3), then req_valid = 1001 → requester 3 granted, then requester 0.
- Reset mid-operation: resp_valid = 1, resp_data = 0xAA, assert rst between clock edges → resp_valid, resp_data, resp_id and txn_count go to 0 immediately. After release with req_valid = 0100, requester 2 is granted first.
- Saturation: preload by 65535 accepts, then 3 more → txn_count stays 0xFFFF; results are still delivered correctly.
